seq_block_subtractor: RTL



---
 rtl/seq_block_subtractor_pkg.sv | 16 +
 rtl/seq_block_subtractor_if.sv | 28 ++
 rtl/seq_block_subtractor_sub_block.sv | 15 +
 rtl/seq_block_subtractor.sv | 100 ++++++++++
 4 files changed

// File: rtl/seq_block_subtractor_pkg.sv
// Shared types for the sequential block subtractor.
//   sub_state_t : controller state encoding (IDLE, RUN, DONE)
//   idx_width   : width of the slice index for a given slice count (never 0)
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic int idx_width(input int nblk);
        return (nblk > 1) ? $clog2(nblk) : 1;
    endfunction

endpackage

// File: rtl/seq_block_subtractor_if.sv
// Operand/result handshake bundle for seq_block_subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (D, Bout, Ovf)
//   master : producer/consumer side, slave : subtractor side
interface seq_block_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, Ovf
    );
endinterface

// File: rtl/seq_block_subtractor_sub_block.sv
// Combinational BLOCK_W-bit slice subtractor.
//   i_a, i_b : slice operands      i_bin  : borrow into the slice
//   o_d      : slice difference    o_bout : borrow out of the slice
module sub_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] i_a,
    input  logic [BLOCK_W-1:0] i_b,
    input  logic               i_bin,
    output logic [BLOCK_W-1:0] o_d,
    output logic               o_bout
);
    // One extra bit catches the borrow as the wrapped MSB.
    assign {o_bout, o_d} = {1'b0, i_a} - {1'b0, i_b} - {{BLOCK_W{1'b0}}, i_bin};
endmodule

// File: rtl/seq_block_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin, one BLOCK_W-bit slice per clock,
// borrow registered between slices.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of seq_block_subtractor_if (operands in, result out)
module seq_block_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int BLOCK_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_block_subtractor_if.slave  bus
);
    localparam int NBLK  = WIDTH / BLOCK_W;
    localparam int IDX_W = idx_width(NBLK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    generate
        if (WIDTH % BLOCK_W != 0) begin : g_bad_block_w
            $error("seq_block_subtractor: WIDTH must be a multiple of BLOCK_W");
        end
    endgenerate

    sub_state_t                   r_state;
    logic [NBLK-1:0][BLOCK_W-1:0] r_a;
    logic [NBLK-1:0][BLOCK_W-1:0] r_b;
    logic [NBLK-1:0][BLOCK_W-1:0] r_d;
    logic                         r_borrow;
    logic                         r_bout;
    logic                         r_ovf;
    logic [IDX_W-1:0]             r_blk_idx;

    logic [BLOCK_W-1:0]           w_d;
    logic                         w_bout;
    logic                         w_a_msb;
    logic                         w_b_msb;

    assign w_a_msb = r_a[NBLK-1][BLOCK_W-1];
    assign w_b_msb = r_b[NBLK-1][BLOCK_W-1];

    sub_block #(.BLOCK_W(BLOCK_W)) u_slice (
        .i_a    (r_a[r_blk_idx]),
        .i_b    (r_b[r_blk_idx]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_d       <= '0;
            r_borrow  <= 1'b0;
            r_bout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_blk_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a       <= bus.A;
                        r_b       <= bus.B;
                        r_borrow  <= bus.Bin;
                        r_blk_idx <= '0;
                        r_d       <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_d[r_blk_idx] <= w_d;
                    r_borrow       <= w_bout;
                    if (r_blk_idx == LAST_IDX) begin
                        r_bout  <= w_bout;
                        // The top slice's difference MSB is the final D MSB.
                        r_ovf   <= (w_a_msb != w_b_msb) && (w_d[BLOCK_W-1] != w_a_msb);
                        r_state <= DONE;
                    end else begin
                        r_blk_idx <= r_blk_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.D         = r_d;
    assign bus.Bout      = r_bout;
    assign bus.Ovf       = r_ovf;

endmodule
